// File: rtl/sub_serial.sv
// Bit-serial 8-bit unsigned subtractor: computes a - b one bit per cycle, LSB first,
// and holds the difference and the final borrow until the next accepted start.
module sub_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] out,
  output logic       borrow,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUB    = 2'd1,
    DONE   = 2'd2,
    UNUSED = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [2:0] count;
  logic       diff_bit;
  logic       borrow_next;

  // One full-subtractor cell working on the current LSBs.
  assign diff_bit    = a_reg[0] ^ b_reg[0] ^ borrow;
  assign borrow_next = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow);

  assign done = (state == DONE);

  always_comb begin
    // NOTE: default assigned first so every path drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = SUB;
      SUB:     if (count == 3'd7) state_next = DONE;
      DONE:    if (!en) state_next = IDLE;
      UNUSED:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= 8'd0;
      b_reg  <= 8'd0;
      count  <= 3'd0;
      out    <= 8'd0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_reg  <= a;
            b_reg  <= b;
            count  <= 3'd0;
            out    <= 8'd0;
            borrow <= 1'b0;
          end
        end
        SUB: begin
          // Difference enters at the MSB so after 8 shifts bit 0 sits at out[0].
          out    <= {diff_bit, out[7:1]};
          borrow <= borrow_next;
          a_reg  <= {1'b0, a_reg[7:1]};
          b_reg  <= {1'b0, b_reg[7:1]};
          count  <= count + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial: hand-computed differences, latency, en handling,
// mid-operation reset and result retention.
module tb_sub_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;
  logic       borrow;
  logic       done;

  int passed = 0;
  int total  = 0;

  sub_serial dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .out    (out),
    .borrow (borrow),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle en pulse; checks latency, result, done drop and retention in IDLE.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp_out, input logic exp_borrow);
    a  = av;
    b  = bv;
    en = 1'b1;
    tick();                       // accepting edge N
    en = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check({tag, "_done_early"}, 8'(done), 8'd0);
    tick();                       // edge N+8
    check({tag, "_done"}, 8'(done), 8'd1);
    check({tag, "_out"}, out, exp_out);
    check({tag, "_borrow"}, 8'(borrow), 8'(exp_borrow));
    tick();                       // en low in DONE -> IDLE
    check({tag, "_done_drop"}, 8'(done), 8'd0);
    check({tag, "_out_held"}, out, exp_out);
    check({tag, "_borrow_held"}, 8'(borrow), 8'(exp_borrow));
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a   = 8'd0;
    b   = 8'd0;
    #1;
    check("rst_out", out, 8'd0);
    check("rst_borrow", 8'(borrow), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    tick();
    tick();
    rst = 1'b0;

    // en low in IDLE: nothing moves.
    a = 8'd77;
    b = 8'd11;
    tick();
    tick();
    check("idle_hold_done", 8'(done), 8'd0);
    check("idle_hold_state", 8'(dut.state), 8'd0);
    check("idle_hold_out", out, 8'd0);

    run_op("op100_37", 8'd100, 8'd37, 8'd63, 1'b0);
    run_op("op5_10", 8'd5, 8'd10, 8'd251, 1'b1);
    run_op("op0_0", 8'd0, 8'd0, 8'd0, 1'b0);
    run_op("op255_1", 8'd255, 8'd1, 8'd254, 1'b0);

    // a=0, b=255 with inputs scrambled during SUB.
    a  = 8'd0;
    b  = 8'd255;
    en = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      en = 1'($urandom);
      tick();
    end
    en = 1'b0;
    tick();
    check("scramble_done", 8'(done), 8'd1);
    check("scramble_out", out, 8'd1);
    check("scramble_borrow", 8'(borrow), 8'd1);
    tick();
    check("scramble_idle", 8'(dut.state), 8'd0);

    // Reset during the 4th SUB cycle.
    a  = 8'd250;
    b  = 8'd3;
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_state", 8'(dut.state), 8'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out", out, 8'd0);
    check("midrst_borrow", 8'(borrow), 8'd0);
    check("midrst_done", 8'(done), 8'd0);
    check("midrst_state", 8'(dut.state), 8'd0);
    #2 rst = 1'b0;
    tick();
    check("postrst_idle", 8'(dut.state), 8'd0);
    run_op("op200_100", 8'd200, 8'd100, 8'd100, 1'b0);

    // en held high for 20 cycles: exactly one operation, no retrigger.
    a  = 8'd9;
    b  = 8'd3;
    en = 1'b1;
    tick();
    a = 8'd1;
    b = 8'd2;
    for (int i = 0; i < 19; i++) tick();
    check("hold_done", 8'(done), 8'd1);
    check("hold_out", out, 8'd6);
    check("hold_borrow", 8'(borrow), 8'd0);
    en = 1'b0;
    tick();
    check("hold_release_done", 8'(done), 8'd0);
    check("hold_release_state", 8'(dut.state), 8'd0);
    check("hold_release_out", out, 8'd6);
    tick();
    check("hold_stay_idle", 8'(dut.state), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
